// File: rtl/collatz_pkg.sv
// Shared types and helpers for the Collatz predecessor walker and its divide-by-3 unit.
package collatz_pkg;

  localparam int unsigned VAL_W      = 16;
  localparam int unsigned PATH_P     = 8;
  localparam int unsigned CNT_W      = $clog2(PATH_P + 1);
  localparam int unsigned DIV_CYCLES = VAL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } walk_state_e;

  typedef struct packed {
    logic [VAL_W-1:0] value;
    logic [CNT_W-1:0] steps;
    logic [CNT_W-1:0] odd;
    logic [CNT_W-1:0] fallback;
    logic             err;
  } walk_result_t;

  // Forward Collatz step, truncated to the value width.
  function automatic logic [VAL_W-1:0] collatz_step(input logic [VAL_W-1:0] n);
    logic [VAL_W+1:0] t;
    t = (VAL_W+2)'(n) + (VAL_W+2)'({n, 1'b0}) + (VAL_W+2)'(1);
    if (n[0]) return t[VAL_W-1:0];
    return n >> 1;
  endfunction

endpackage

// File: rtl/div3_seq.sv
// Restoring radix-2 divider by the constant 3; first bit is resolved on the start edge,
// so quotient and remainder are valid in the done cycle exactly W cycles later.
module div3_seq
  import collatz_pkg::*;
#(
  parameter int unsigned W = VAL_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [1:0]   rem
);

  localparam int unsigned CW = $clog2(W + 1);

  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] quo_q, quo_d;
  logic [1:0]   rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // One restoring iteration: returns {remainder, shifted quotient/dividend}.
  function automatic logic [W+1:0] div_iter(input logic [1:0] r, input logic [W-1:0] q);
    logic [2:0] part;
    part = {r, q[W-1]};
    if (part >= 3'd3) return {2'(part - 3'd3), q[W-2:0], 1'b1};
    return {part[1:0], q[W-2:0], 1'b0};
  endfunction

  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    quo_d  = quo_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    if (start) begin
      {rem_d, quo_d} = div_iter(2'b00, dividend);
      cnt_d          = CW'(W - 1);
      busy_d         = 1'b1;
    end else if (busy_q) begin
      {rem_d, quo_d} = div_iter(rem_q, quo_q);
      cnt_d          = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/collatz_predecessor_walker.sv
// Walks the Collatz tree backwards from a seed along a path of even/odd branch choices.
module collatz_predecessor_walker
  import collatz_pkg::*;
#(
  parameter  int unsigned W  = VAL_W,
  parameter  int unsigned P  = PATH_P,
  localparam int unsigned LW = $clog2(P + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_seed,
  input  logic [P-1:0]  in_path,
  input  logic [LW-1:0] in_len,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_value,
  output logic [LW-1:0] out_steps,
  output logic [LW-1:0] out_odd,
  output logic [LW-1:0] out_fallback,
  output logic          out_err
);

  walk_state_e   state_q, state_d;
  logic [W-1:0]  n_q, n_d;
  logic [P-1:0]  path_q, path_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] steps_q, steps_d;
  logic [LW-1:0] odd_q, odd_d;
  logic [LW-1:0] fb_q, fb_d;
  logic          err_q, err_d;

  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_value_q, out_value_d;
  logic [LW-1:0] out_steps_q, out_steps_d;
  logic [LW-1:0] out_odd_q, out_odd_d;
  logic [LW-1:0] out_fb_q, out_fb_d;
  logic          out_err_q, out_err_d;

  logic          div_start_c;
  logic          div_busy;
  logic          div_done;
  logic [W-1:0]  div_quot;
  logic [1:0]    div_rem;
  logic          go_even;
  logic          step_done;

  div3_seq #(.W(W)) u_div3 (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_c),
    .dividend (n_q - W'(1)),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    path_d      = path_q;
    len_d       = len_q;
    steps_d     = steps_q;
    odd_d       = odd_q;
    fb_d        = fb_q;
    err_d       = err_q;
    div_start_c = 1'b0;
    go_even     = 1'b0;
    step_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          n_d     = in_seed;
          path_d  = in_path;
          len_d   = in_len;
          steps_d = '0;
          odd_d   = '0;
          fb_d    = '0;
          err_d   = (in_seed == '0);
          if (in_seed == '0 || in_len == '0) state_d = S_DONE;
          else                               state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (path_q[0]) begin
          if (!div_busy) begin
            div_start_c = 1'b1;
            state_d     = S_DIV;
          end
        end else begin
          go_even = 1'b1;
        end
      end
      S_DIV: begin
        // Odd predecessor exists only for n mod 6 == 4, excluding the 4 -> 1 loop.
        if (div_done) begin
          if (div_rem == 2'd0 && !n_q[0] && div_quot != W'(1)) begin
            n_d       = div_quot;
            odd_d     = odd_q + LW'(1);
            step_done = 1'b1;
          end else begin
            fb_d    = fb_q + LW'(1);
            go_even = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_even) begin
      if (n_q[W-1]) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end else begin
        n_d       = {n_q[W-2:0], 1'b0};
        step_done = 1'b1;
      end
    end

    if (step_done) begin
      steps_d = steps_q + LW'(1);
      path_d  = path_q >> 1;
      state_d = (steps_d == len_q) ? S_DONE : S_STEP;
    end
  end

  // Result registers are loaded only when a job enters DONE.
  always_comb begin
    out_value_d = out_value_q;
    out_steps_d = out_steps_q;
    out_odd_d   = out_odd_q;
    out_fb_d    = out_fb_q;
    out_err_d   = out_err_q;
    if (state_q != S_DONE && state_d == S_DONE) begin
      out_value_d = n_d;
      out_steps_d = steps_d;
      out_odd_d   = odd_d;
      out_fb_d    = fb_d;
      out_err_d   = err_d;
    end
    out_valid_d = (state_d == S_DONE);
    in_ready_d  = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      path_q      <= '0;
      len_q       <= '0;
      steps_q     <= '0;
      odd_q       <= '0;
      fb_q        <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_steps_q <= '0;
      out_odd_q   <= '0;
      out_fb_q    <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      path_q      <= path_d;
      len_q       <= len_d;
      steps_q     <= steps_d;
      odd_q       <= odd_d;
      fb_q        <= fb_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_steps_q <= out_steps_d;
      out_odd_q   <= out_odd_d;
      out_fb_q    <= out_fb_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_value    = out_value_q;
  assign out_steps    = out_steps_q;
  assign out_odd      = out_odd_q;
  assign out_fallback = out_fb_q;
  assign out_err      = out_err_q;

endmodule
